// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit for a pipelined core.
//   Shift-add multiply and restoring divide, one bit per enabled cycle, followed by a
//   sign-correction cycle (FIX) and a one-cycle result cycle (DONE).
//   Build option: define MULDIV_SIGNED_EN to enable signed MULT/DIV; when it is undefined,
//   op_in[0] is ignored and every operation is unsigned.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  pipeline enable (0 freezes all state)
//   start_in, op_in     request and operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   data_a_in/_b_in     operands, sampled at accept
//   flush_in            abort any operation in flight
//   busy_out            state is not IDLE
//   stall_out           combinational pipeline hold request
//   done_out            completion pulse; div_by_zero_out flags a zero divisor
//   hi_data_out         product upper half / remainder
//   lo_data_out         product lower half / quotient
module muldiv_sequencer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start_in,
   input  logic [1:0]            op_in,
   input  logic [DATA_WIDTH-1:0] data_a_in,
   input  logic [DATA_WIDTH-1:0] data_b_in,
   input  logic                  flush_in,
   output logic                  busy_out,
   output logic                  stall_out,
   output logic                  done_out,
   output logic                  div_by_zero_out,
   output logic [DATA_WIDTH-1:0] hi_data_out,
   output logic [DATA_WIDTH-1:0] lo_data_out
);

   localparam int unsigned W = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CntW-1:0] LastIter = CntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2*W-1:0]  work_q;   // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [W-1:0]    opnd_q;   // multiplicand or divisor magnitude
   logic            is_div_q;
   logic            done_q;
   logic            dbz_q;
   logic [W-1:0]    hi_q;
   logic [W-1:0]    lo_q;
`ifdef MULDIV_SIGNED_EN
   logic            neg_res_q;  // product / quotient must be negated
   logic            neg_rem_q;  // remainder follows the dividend's sign
`endif

   // Operand magnitudes and signs at accept time.
   logic [W-1:0] mag_a;
   logic [W-1:0] mag_b;
`ifdef MULDIV_SIGNED_EN
   logic sign_a;
   logic sign_b;
   always_comb begin
      sign_a = op_in[0] & data_a_in[W-1];
      sign_b = op_in[0] & data_b_in[W-1];
      mag_a  = sign_a ? -data_a_in : data_a_in;
      mag_b  = sign_b ? -data_b_in : data_b_in;
   end
`else
   logic unused_op0;
   assign unused_op0 = op_in[0];
   always_comb begin
      mag_a = data_a_in;
      mag_b = data_b_in;
   end
`endif

   // One iteration of the shift-add multiply or restoring divide.
   logic [W:0]     add_sum;
   logic [W:0]     div_shift;
   logic [W:0]     div_diff;
   logic [2*W-1:0] iter_d;
   always_comb begin
      add_sum   = {1'b0, work_q[2*W-1:W]} + {1'b0, opnd_q};
      div_shift = {work_q[2*W-1:W], work_q[W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (is_div_q) begin
         // Top bit of the difference set means the trial subtract went negative: restore.
         if (!div_diff[W]) iter_d = {div_diff[W-1:0], work_q[W-2:0], 1'b1};
         else              iter_d = {div_shift[W-1:0], work_q[W-2:0], 1'b0};
      end else if (work_q[0]) begin
         iter_d = {add_sum, work_q[W-1:1]};
      end else begin
         iter_d = {1'b0, work_q[2*W-1:1]};
      end
   end

   // Sign correction applied in FIX.
   logic [W-1:0] fix_hi;
   logic [W-1:0] fix_lo;
   always_comb begin
      fix_hi = work_q[2*W-1:W];
      fix_lo = work_q[W-1:0];
`ifdef MULDIV_SIGNED_EN
      if (is_div_q) begin
         if (neg_rem_q) fix_hi = -work_q[2*W-1:W];
         if (neg_res_q) fix_lo = -work_q[W-1:0];
      end else if (neg_res_q) begin
         {fix_hi, fix_lo} = -work_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         work_q    <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
`ifdef MULDIV_SIGNED_EN
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else if (flush_in) begin
         // Abort wins over enable; results of the aborted operation are never written.
         state_q <= StIdle;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else if (en) begin
         unique case (state_q)
            StIdle: begin
               if (start_in) begin
                  is_div_q <= op_in[1];
                  cnt_q    <= '0;
                  if (op_in[1] && (data_b_in == '0)) begin
                     hi_q    <= data_a_in;
                     lo_q    <= '1;
                     done_q  <= 1'b1;
                     dbz_q   <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     work_q  <= op_in[1] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
                     opnd_q  <= op_in[1] ? mag_b : mag_a;
                     state_q <= StCalc;
                  end
`ifdef MULDIV_SIGNED_EN
                  neg_res_q <= sign_a ^ sign_b;
                  neg_rem_q <= sign_a;
`endif
               end
            end
            StCalc: begin
               work_q <= iter_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LastIter) state_q <= StFix;
            end
            StFix: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               done_q  <= 1'b1;
               dbz_q   <= 1'b0;
               state_q <= StDone;
            end
            StDone: begin
               done_q  <= 1'b0;
               dbz_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_out        = (state_q != StIdle);
   assign stall_out       = (!rst && (state_q == StIdle) && en && start_in && !flush_in)
                            || (state_q == StCalc) || (state_q == StFix);
   assign done_out        = done_q;
   assign div_by_zero_out = dbz_q;
   assign hi_data_out     = hi_q;
   assign lo_data_out     = lo_q;

endmodule
